// File: rtl/inv_mix_columns_seq_if.sv
// Handshake bundle for the iterative InvMixColumns engine.
// Input side: IN_VALID/IN_READY/DIN.
// Output side: OUT_VALID/OUT_READY/DOUT.
// Each 128-bit state holds column c at [127-32c -: 32]. Row 0 is the MSB byte of the column.
// The engine connects through the slave modport.
// The producer/consumer connects through the master modport.
interface inv_mix_columns_seq_if;
    logic         IN_VALID;
    logic         IN_READY;
    logic [127:0] DIN;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [127:0] DOUT;

    modport slave (
        input  IN_VALID, DIN, OUT_READY,
        output IN_READY, OUT_VALID, DOUT
    );

    modport master (
        output IN_VALID, DIN, OUT_READY,
        input  IN_READY, OUT_VALID, DOUT
    );
endinterface

// File: rtl/inv_mix_columns_seq.sv
// Purpose: iterative AES InvMixColumns over one 128-bit state, COLS_PER_CYCLE columns per clock.
// Latency: OUT_VALID rises 4/COLS_PER_CYCLE edges after the accept edge.
// Backpressure: IN_READY is high only in IDLE. A result is held in DONE until OUT_READY.
// Ports: CLK, RST (async active-high).
// Ports: bus.slave carries IN_VALID/IN_READY/DIN and OUT_VALID/OUT_READY/DOUT.
module inv_mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    inv_mix_columns_seq_if.slave  bus
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // The counter is 2 bits wide, so a step of 4 wraps to 0.
    // The column counter therefore lands back on 0 when the block finishes.
    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    // Packed index 3 is column 0, so DIN maps straight onto the array.
    logic [3:0][31:0]  work_q, work_d;
    logic [127:0]      dout_q, dout_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic [1:0]        col_idx;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Returns {0E*a, 0B*a, 0D*a, 09*a}, built from one shared xtime chain.
    function automatic logic [31:0] inv_mults(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return {x8 ^ x4 ^ x2, x8 ^ x2 ^ a, x8 ^ x4 ^ a, x8 ^ a};
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [31:0] m0, m1, m2, m3;
        logic [7:0]  b0, b1, b2, b3;
        m0 = inv_mults(c[31:24]);
        m1 = inv_mults(c[23:16]);
        m2 = inv_mults(c[15:8]);
        m3 = inv_mults(c[7:0]);
        // Field slices: [31:24]=0E, [23:16]=0B, [15:8]=0D, [7:0]=09.
        b0 = m0[31:24] ^ m1[23:16] ^ m2[15:8]  ^ m3[7:0];
        b1 = m0[7:0]   ^ m1[31:24] ^ m2[23:16] ^ m3[15:8];
        b2 = m0[15:8]  ^ m1[7:0]   ^ m2[31:24] ^ m3[23:16];
        b3 = m0[23:16] ^ m1[15:8]  ^ m2[7:0]   ^ m3[31:24];
        return {b0, b1, b2, b3};
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        col_idx     = 2'd0;

        case (state_q)
            ST_IDLE: begin
                if (bus.IN_VALID) begin
                    work_d     = bus.DIN;
                    cnt_d      = 2'd0;
                    state_d    = ST_BUSY;
                    in_ready_d = 1'b0;
                end
            end
            ST_BUSY: begin
                for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                    col_idx = cnt_q + 2'(g);
                    work_d[2'd3 - col_idx] = inv_col(work_q[2'd3 - col_idx]);
                end
                cnt_d = cnt_q + STEP;
                if (cnt_q == LAST) begin
                    // work_d already holds the final column group.
                    dout_d      = work_d;
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.OUT_READY) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            work_q      <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.IN_READY  = in_ready_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.DOUT      = dout_q;

endmodule
